// File: rtl/apb4_mem_slave_if.sv
// APB4 bus bundle for the memory slave: master drives the request side,
// slave returns read data, ready and error.
interface apb4_mem_slave_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_mem_slave.sv
// APB4 scratch/config memory slave with byte strobes, fixed wait states,
// a read-only low region and a privileged high region.
module apb4_mem_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1,
  parameter int RO_WORDS    = 4,
  parameter int PRIV_BASE   = 192
) (
  input logic              pclk,
  input logic              preset,
  apb4_mem_slave_if.slave  bus
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFS = $clog2(NB);
  localparam int MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // Transfer captured in the setup cycle; held stable through the access.
  typedef struct packed {
    logic                  wr;
    logic                  err;
    logic [MW-1:0]         idx;
    logic [DATA_WIDTH-1:0] wdata;
    logic [NB-1:0]         strb;
  } req_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  req_t                  req, req_n, req_in;
  logic                  ready, ready_n;
  logic                  slverr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  commit;

  logic                  setup;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           idx32;
  logic                  misalign, oor, priv_fault, ro_fault;
  logic                  unused_prot;

  assign setup      = bus.psel & ~bus.penable;
  assign idx        = bus.paddr >> OFS;
  assign idx32      = 32'(idx);
  assign misalign   = (bus.paddr & ADDR_WIDTH'(NB - 1)) != '0;
  assign oor        = idx32 >= 32'(DEPTH);
  assign priv_fault = ~bus.pprot[0] & (idx32 >= 32'(PRIV_BASE));
  assign ro_fault   = bus.pwrite & (idx32 < 32'(RO_WORDS));
  // pprot[2:1] (secure / instruction) carry no meaning for this memory.
  assign unused_prot = ^bus.pprot[2:1];

  always_comb begin
    req_in       = '0;
    req_in.wr    = bus.pwrite;
    req_in.err   = misalign | oor | priv_fault | ro_fault;
    req_in.idx   = idx[MW-1:0];
    req_in.wdata = bus.pwdata;
    req_in.strb  = bus.pstrb;
  end

  // Next-state: capture on setup, count wait states, one-cycle completion, DONE gap.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_n   = req;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (setup) begin
          state_n = ACCESS;
          cnt_n   = 4'(WAIT_STATES);
          req_n   = req_in;
        end
      end
      ACCESS: begin
        if (!bus.psel) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt != '0) begin
          if (bus.penable) cnt_n = cnt - 4'd1;
        end else begin
          state_n = DONE;
          commit  = req.wr & ~req.err;
        end
      end
      DONE: begin
        if (setup) begin
          state_n = ACCESS;
          cnt_n   = 4'(WAIT_STATES);
          req_n   = req_in;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // pready is raised for the cycle in which ACCESS sits with the counter at zero.
    ready_n = (state_n == ACCESS) && (cnt_n == '0);
  end

  // State, registered handshake outputs and read data.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state  <= IDLE;
      cnt    <= '0;
      req    <= '0;
      ready  <= 1'b0;
      slverr <= 1'b0;
      rdata  <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      req    <= req_n;
      ready  <= ready_n;
      slverr <= ready_n & req_n.err;
      if (ready_n && !req_n.wr) rdata <= req_n.err ? '0 : mem[req_n.idx];
    end
  end

  // Byte-lane write at the edge that closes the pready cycle; contents survive reset.
  always_ff @(posedge pclk) begin
    if (commit && !preset) begin
      for (int b = 0; b < NB; b++) begin
        if (req.strb[b]) mem[req.idx][b*8 +: 8] <= req.wdata[b*8 +: 8];
      end
    end
  end

  assign bus.pready  = ready;
  assign bus.pslverr = slverr;
  assign bus.prdata  = rdata;
endmodule
